// File: rtl/data_mem_access_unit.sv
// Load/store sequencer for a synchronous data memory: one request at a time,
// single-cycle strobe, waits out the clocked read, returns data/ack/error.
module data_mem_access_unit #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_wrt,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  txn_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

    state_t              r_state, w_next;
    logic                r_we;
    logic                r_rsp_valid, r_rsp_err, r_mem_read, r_mem_wrt;
    logic [DATA_W-1:0]   r_rsp_data, r_mem_wdata;
    logic [31:0]         r_mem_addr;
    logic [CNT_W-1:0]    r_txn_count;
    logic                w_accept, w_oor, w_rsp_fire;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_oor      = |req_addr[31:ADDR_BITS];
    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = w_oor ? S_RESP : S_ACCESS;
            S_ACCESS:  w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    if (w_rsp_fire) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Strobes are registered; async reset removes them before the memory edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_wrt   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_we <= req_we;
                    if (w_oor) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_mem_addr  <= req_addr;
                        r_mem_wdata <= req_wdata;
                        r_mem_read  <= ~req_we;
                        r_mem_wrt   <= req_we;
                    end
                end
                S_ACCESS: begin
                    r_mem_read <= 1'b0;
                    r_mem_wrt  <= 1'b0;
                end
                S_CAPTURE: begin
                    r_rsp_data  <= r_we ? '0 : mem_rdata;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_txn_count <= r_txn_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign mem_read  = r_mem_read;
    assign mem_wrt   = r_mem_wrt;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a small synchronous memory model.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        mem_read, mem_wrt;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [15:0] txn_count;

    int vectors = 0;
    int miscompares = 0;
    int wrt_cycles = 0;
    int rd_cycles = 0;
    int both_high = 0;

    logic [31:0] mem [0:255];

    data_mem_access_unit #(.ADDR_BITS(16), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_wrt(mem_wrt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // synchronous data memory plus strobe monitors
    always @(posedge clk) begin
        if (mem_wrt) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_wrt) wrt_cycles++;
        if (mem_read) rd_cycles++;
        if (mem_read && mem_wrt) both_high++;
    end

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        vectors++; if ({mem_read, mem_wrt} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes got %b exp 00", {mem_read, mem_wrt}); end
        vectors++; if (txn_count !== 16'd0) begin miscompares++; $display("FAIL reset_txn got %0d exp 0", txn_count); end
        vectors++; if ({rsp_data, mem_addr} !== 64'd0) begin miscompares++; $display("FAIL reset_data_addr got %h exp 0", {rsp_data, mem_addr}); end
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEADBEEF; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if ({mem_wrt, mem_read} !== 2'b10 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL st_strobe got wrt=%b rd=%b addr=%h wd=%h exp 1 0 5 deadbeef", mem_wrt, mem_read, mem_addr, mem_wdata); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL st_busy got %b exp 0", req_ready); end
        @(negedge clk);
        vectors++; if (mem_wrt !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL st_capture got wrt=%b vld=%b exp 0 0", mem_wrt, rsp_valid); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
            miscompares++; $display("FAIL st_ack got vld=%b data=%h err=%b exp 1 0 0", rsp_valid, rsp_data, rsp_err); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0 || txn_count !== 16'd1 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL st_done got vld=%b txn=%0d rdy=%b exp 0 1 1", rsp_valid, txn_count, req_ready); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if ({mem_read, mem_wrt} !== 2'b10) begin miscompares++; $display("FAIL ld_strobe got rd/wrt=%b exp 10", {mem_read, mem_wrt}); end
        @(negedge clk);
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            miscompares++; $display("FAIL ld_data got vld=%b data=%h err=%b exp 1 deadbeef 0", rsp_valid, rsp_data, rsp_err); end
        @(negedge clk);
        vectors++; if (txn_count !== 16'd2) begin miscompares++; $display("FAIL ld_txn got %0d exp 2", txn_count); end
    endtask

    task automatic test_out_of_range();
        int rd0;
        rd0 = rd_cycles;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0001_0000; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
            miscompares++; $display("FAIL oor_rsp got vld=%b err=%b data=%h exp 1 1 0", rsp_valid, rsp_err, rsp_data); end
        vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL oor_strobe got %b exp 0", mem_read); end
        @(negedge clk);
        vectors++; if (rd_cycles !== rd0 || txn_count !== 16'd3 || rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL oor_done got reads=%0d txn=%0d vld=%b exp %0d 3 0", rd_cycles - rd0, txn_count, rsp_valid, 0); end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5; rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h1111_2222;  // should be ignored while busy
        repeat (2) @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL bp_first got vld=%b data=%h exp 1 deadbeef", rsp_valid, rsp_data); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || req_ready !== 1'b0 || txn_count !== 16'd3 || mem_wrt !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0 || txn_count !== 16'd4) begin
            miscompares++; $display("FAIL bp_release got vld=%b txn=%0d exp 0 4", rsp_valid, txn_count); end
    endtask

    task automatic test_back_to_back();
        int w0, cyc;
        w0 = wrt_cycles;
        req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            while (req_ready !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
            vectors++; if (cyc >= 10) begin miscompares++; $display("FAIL b2b_wait%0d got timeout exp ready", i); end
            req_addr = i; req_wdata = 32'd100 + i;
            @(negedge clk);
            if (i == 2) req_valid = 1'b0;
            vectors++; if (req_ready !== 1'b0 || mem_wrt !== 1'b1 || mem_addr !== i) begin
                miscompares++; $display("FAIL b2b_acc%0d got rdy=%b wrt=%b addr=%0d exp 0 1 %0d", i, req_ready, mem_wrt, mem_addr, i); end
        end
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        vectors++; if (wrt_cycles - w0 != 3 || txn_count !== 16'd7 || both_high != 0) begin
            miscompares++; $display("FAIL b2b_total got wrts=%0d txn=%0d both=%0d exp 3 7 0", wrt_cycles - w0, txn_count, both_high); end
        vectors++; if (mem[1] !== 32'd101 || mem[2] !== 32'd102) begin
            miscompares++; $display("FAIL b2b_mem got %0d %0d exp 101 102", mem[1], mem[2]); end
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h1234_5678; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (mem_wrt !== 1'b1) begin miscompares++; $display("FAIL rm_access got wrt=%b exp 1", mem_wrt); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (mem_wrt !== 1'b0) begin miscompares++; $display("FAIL rm_drop got wrt=%b exp 0", mem_wrt); end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || txn_count !== 16'd0) begin
            miscompares++; $display("FAIL rm_idle got rdy=%b vld=%b txn=%0d exp 1 0 0", req_ready, rsp_valid, txn_count); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BAD_F00D) begin
            miscompares++; $display("FAIL rm_load got vld=%b data=%h exp 1 0badf00d", rsp_valid, rsp_data); end
        @(negedge clk);
        vectors++; if (txn_count !== 16'd1 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL rm_txn got txn=%0d rdy=%b exp 1 1", txn_count, req_ready); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[7] = 32'h0BAD_F00D;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
